// File: rtl/gate_arbiter.sv
// -----------------------------------------------------------------------------
// gate_arbiter
//   Two-lane round-robin arbiter for a single shared barrier gate. A lane that
//   is granted keeps the gate open until its vehicle passes (entry sensor),
//   leaves (request drops) or overstays (timeout -> alarm until acknowledged).
//   After every normal release the gate is held closed for CLOSE_CYC cycles.
//
// Parameters
//   TIMEOUT    cycles a granted lane may hold the gate open (>= 2)
//   CLOSE_CYC  cycles the gate stays closed after a release (>= 1)
//
// Ports
//   i_clock         single clock, rising-edge active
//   i_reset         synchronous active-high reset
//   i_req0/i_req1   lane arrival sensors (level)
//   i_entSensor     shared entry sensor, vehicle has passed the gate
//   i_alarmAck      operator acknowledge for the timeout alarm
//   o_grant0/1      lane ownership of the gate
//   o_gateOpen      gate open command
//   o_gateClose     gate close command
//   o_timeoutAlarm  granted lane overstayed TIMEOUT
//   o_prio          lane favoured on the next simultaneous request
// -----------------------------------------------------------------------------
module gate_arbiter #(
  parameter logic [7:0] TIMEOUT   = 8'd100,
  parameter logic [3:0] CLOSE_CYC = 4'd4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_entSensor,
  input  logic i_alarmAck,
  output logic o_grant0,
  output logic o_grant1,
  output logic o_gateOpen,
  output logic o_gateClose,
  output logic o_timeoutAlarm,
  output logic o_prio
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    CLOSING = 2'd2,
    ALARM   = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_timer;
  logic [3:0] r_close_cnt;
  logic       r_lane;       // lane currently (or most recently) granted
  logic       r_prio;
  logic       r_grant0;
  logic       r_grant1;
  logic       r_gate_open;
  logic       r_gate_close;
  logic       r_alarm;

  state_t     w_state_nxt;
  logic [7:0] w_timer_nxt;
  logic [3:0] w_close_nxt;
  logic       w_lane_nxt;
  logic       w_prio_nxt;
  logic       w_lane_req;
  logic       w_open_nxt;

  // Next-state, counter and round-robin pointer decisions
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_close_nxt = r_close_cnt;
    w_lane_nxt  = r_lane;
    w_prio_nxt  = r_prio;
    w_lane_req  = r_lane ? i_req1 : i_req0;

    case (r_state)
      IDLE: begin
        if (i_req0 && i_req1) begin
          w_state_nxt = OPEN;
          w_lane_nxt  = r_prio;
          w_timer_nxt = 8'd0;
        end else if (i_req0) begin
          w_state_nxt = OPEN;
          w_lane_nxt  = 1'b0;
          w_timer_nxt = 8'd0;
        end else if (i_req1) begin
          w_state_nxt = OPEN;
          w_lane_nxt  = 1'b1;
          w_timer_nxt = 8'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      OPEN: begin
        // Vehicle passed or left beats the timeout in the same cycle.
        if (i_entSensor || !w_lane_req) begin
          w_state_nxt = CLOSING;
          w_close_nxt = 4'd0;
          w_prio_nxt  = ~r_lane;
        end else if (r_timer == (TIMEOUT - 8'd1)) begin
          w_state_nxt = ALARM;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end

      CLOSING: begin
        if (r_close_cnt == (CLOSE_CYC - 4'd1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_close_nxt = r_close_cnt + 4'd1;
        end
      end

      ALARM: begin
        if (i_alarmAck) begin
          w_state_nxt = IDLE;
          w_prio_nxt  = ~r_lane;
        end else begin
          w_state_nxt = ALARM;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_open_nxt = (w_state_nxt == OPEN);
  end

  // State, counters and registered outputs derived from the next state
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_timer      <= 8'd0;
      r_close_cnt  <= 4'd0;
      r_lane       <= 1'b0;
      r_prio       <= 1'b0;
      r_grant0     <= 1'b0;
      r_grant1     <= 1'b0;
      r_gate_open  <= 1'b0;
      r_gate_close <= 1'b1;
      r_alarm      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_close_cnt  <= w_close_nxt;
      r_lane       <= w_lane_nxt;
      r_prio       <= w_prio_nxt;
      r_grant0     <= w_open_nxt && !w_lane_nxt;
      r_grant1     <= w_open_nxt && w_lane_nxt;
      r_gate_open  <= w_open_nxt;
      r_gate_close <= !w_open_nxt;
      r_alarm      <= (w_state_nxt == ALARM);
    end
  end

  assign o_grant0       = r_grant0;
  assign o_grant1       = r_grant1;
  assign o_gateOpen     = r_gate_open;
  assign o_gateClose    = r_gate_close;
  assign o_timeoutAlarm = r_alarm;
  assign o_prio         = r_prio;

endmodule
